vend_ctrl: RTL and testbench

Vending transaction controller: accumulates inserted coin value as credit, accepts an item selection, and drives the select input of the price-lookup multiplexer. It consumes the looked-up price, then either dispenses the item or flags insufficient credit, and returns change through a valid/ack handshake. It sits directly upstream of the price mux, driving its `sel` and consuming its `out`, and below the top-level I/O.

---
 rtl/vend_ctrl_pkg.sv | 22 ++
 rtl/vend_ctrl_if.sv | 37 +++
 rtl/vend_credit.sv | 44 ++++
 rtl/vend_ctrl.sv | 129 ++++++++++++
 tb/tb_vend_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/vend_ctrl_pkg.sv
// Purpose: shared types and helpers for the vending transaction controller.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package vend_ctrl_pkg;

    localparam int VEND_N_DEF     = 2;
    localparam int VEND_DATAW_DEF = 4;

    // Controller states; the 2-bit encoding is visible in waveforms, so keep it stable.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CHECK   = 2'd2,
        ST_CHANGE  = 2'd3
    } state_t;

    // The machine is busy whenever it cannot take a new coin or selection.
    function automatic logic state_busy(input state_t st);
        return (st == ST_CHECK) || (st == ST_CHANGE);
    endfunction

endpackage

// File: rtl/vend_ctrl_if.sv
// Purpose: bundle of vending controller I/O (coin/item/cancel strobes, price-mux link, change handshake, status).
// Latency: n/a (wires only).
// Backpressure: change is held until change_ack; strobes carry no backpressure.
interface vend_ctrl_if #(
    parameter int N     = 2,
    parameter int DATAW = 4
);
    logic             coin_valid;
    logic [DATAW-1:0] coin_val;
    logic             item_valid;
    logic [N-1:0]     item_sel;
    logic             cancel;
    logic [DATAW-1:0] price;
    logic             change_ack;
    logic [N-1:0]     mux_sel;
    logic             dispense;
    logic             insufficient;
    logic             coin_reject;
    logic             change_valid;
    logic [DATAW-1:0] change_amt;
    logic [DATAW-1:0] credit;
    logic             busy;

    // Controller side.
    modport slave (
        input  coin_valid, coin_val, item_valid, item_sel, cancel, price, change_ack,
        output mux_sel, dispense, insufficient, coin_reject, change_valid, change_amt,
               credit, busy
    );

    // Environment side (front panel, price mux, change hopper).
    modport master (
        output coin_valid, coin_val, item_valid, item_sel, cancel, price, change_ack,
        input  mux_sel, dispense, insufficient, coin_reject, change_valid, change_amt,
               credit, busy
    );
endinterface

// File: rtl/vend_credit.sv
// Purpose: credit accumulator with overflow-checked add, non-wrapping subtract and clear.
// Latency: credit_q updates one cycle after the control strobe; credit_d/add_ovf are combinational.
// Backpressure: none; an overflowing add is dropped and flagged on add_ovf.
// Ports: add_en/add_val add a coin, sub_en/sub_val pay a price, clr empties credit,
//        credit_q is the held credit, credit_d the value it takes at the next edge.
module vend_credit #(
    parameter int DATAW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             add_en,
    input  logic [DATAW-1:0] add_val,
    input  logic             sub_en,
    input  logic [DATAW-1:0] sub_val,
    input  logic             clr,
    output logic [DATAW-1:0] credit_q,
    output logic [DATAW-1:0] credit_d,
    output logic             add_ovf
);
    logic [DATAW:0] sum;

    always_comb begin
        // One extra bit so a carry out marks a sum above the representable maximum.
        sum      = {1'b0, credit_q} + {1'b0, add_val};
        add_ovf  = add_en & sum[DATAW];
        credit_d = credit_q;
        if (clr) begin
            credit_d = '0;
        end else if (sub_en) begin
            // Caller only subtracts when credit >= sub_val, so this never wraps.
            credit_d = credit_q - sub_val;
        end else if (add_en && !sum[DATAW]) begin
            credit_d = sum[DATAW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_q <= '0;
        end else begin
            credit_q <= credit_d;
        end
    end
endmodule

// File: rtl/vend_ctrl.sv
// Purpose: vending transaction FSM: collects coins, checks the looked-up price, dispenses and returns change.
// Latency: item_valid -> one CHECK cycle -> dispense/insufficient the cycle after; all outputs registered.
// Backpressure: change is held on change_valid until change_ack; coins arriving while busy are rejected.
// Ports: clk, rst (async active-high); bus carries coin/item/cancel strobes, the price-mux
//        select/price pair, the change valid/ack handshake and credit/busy status.
module vend_ctrl
    import vend_ctrl_pkg::*;
#(
    parameter int N     = VEND_N_DEF,
    parameter int DATAW = VEND_DATAW_DEF
) (
    input  logic       clk,
    input  logic       rst,
    vend_ctrl_if.slave bus
);
    state_t           state_q, state_d;
    logic [N-1:0]     mux_sel_q, mux_sel_d;
    logic             dispense_q, dispense_d;
    logic             insufficient_q, insufficient_d;
    logic             coin_reject_q, coin_reject_d;
    logic             change_valid_q, change_valid_d;
    logic [DATAW-1:0] change_amt_q, change_amt_d;
    logic             busy_q, busy_d;

    logic             add_en;
    logic             sub_en;
    logic             clr;
    logic             add_ovf;
    logic             price_ok;
    logic [DATAW-1:0] credit_q;
    logic [DATAW-1:0] credit_d;

    // Datapath controls depend only on current state and inputs, never on credit_d,
    // which keeps the next-state logic free of combinational loops.
    assign price_ok = (credit_q >= bus.price);
    assign add_en   = bus.coin_valid && ((state_q == ST_IDLE) || (state_q == ST_COLLECT));
    assign sub_en   = (state_q == ST_CHECK) && price_ok;
    assign clr      = (state_q == ST_CHANGE) && bus.change_ack;

    vend_credit #(.DATAW(DATAW)) u_credit (
        .clk      (clk),
        .rst      (rst),
        .add_en   (add_en),
        .add_val  (bus.coin_val),
        .sub_en   (sub_en),
        .sub_val  (bus.price),
        .clr      (clr),
        .credit_q (credit_q),
        .credit_d (credit_d),
        .add_ovf  (add_ovf)
    );

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            mux_sel_q      <= '0;
            dispense_q     <= 1'b0;
            insufficient_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            mux_sel_q      <= mux_sel_d;
            dispense_q     <= dispense_d;
            insufficient_q <= insufficient_d;
            coin_reject_q  <= coin_reject_d;
            change_valid_q <= change_valid_d;
            change_amt_q   <= change_amt_d;
            busy_q         <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        mux_sel_d = mux_sel_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.coin_valid) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                // credit_d already includes a same-cycle coin, so cancel refunds it too.
                if (bus.cancel) begin
                    state_d = (credit_d != '0) ? ST_CHANGE : ST_IDLE;
                end else if (bus.item_valid) begin
                    mux_sel_d = bus.item_sel;
                    state_d   = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (price_ok) begin
                    state_d = (credit_d != '0) ? ST_CHANGE : ST_IDLE;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_CHANGE: begin
                if (bus.change_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic, registered one cycle later alongside the state.
    always_comb begin
        dispense_d     = (state_q == ST_CHECK) && price_ok;
        insufficient_d = (state_q == ST_CHECK) && !price_ok;
        coin_reject_d  = add_ovf || (bus.coin_valid && state_busy(state_q));
        change_valid_d = (state_d == ST_CHANGE);
        change_amt_d   = (state_d == ST_CHANGE) ? credit_d : '0;
        busy_d         = state_busy(state_d);
    end

    assign bus.mux_sel      = mux_sel_q;
    assign bus.dispense     = dispense_q;
    assign bus.insufficient = insufficient_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.change_valid = change_valid_q;
    assign bus.change_amt   = change_amt_q;
    assign bus.credit       = credit_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_vend_ctrl.sv
// Purpose: self-checking bench for vend_ctrl with a price mux of {3,5,7,9}.
// Latency: outputs compared every negedge against a transaction-level reference.
// Backpressure: change_ack driven by the bench, directed then random.
module tb_vend_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vend_ctrl_if #(.N(2), .DATAW(4)) bus ();

    vend_ctrl #(.N(2), .DATAW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Price mux stand-in.
    logic [3:0] price_tab [4] = '{4'd3, 4'd5, 4'd7, 4'd9};
    assign bus.price = price_tab[bus.mux_sel];

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks the transaction phase and the money; pulses describe the last edge.
    localparam int P_IDLE = 0, P_COLLECT = 1, P_CHECK = 2, P_CHANGE = 3;
    int m_phase  = P_IDLE;
    int m_credit = 0;
    int m_sel    = 0;
    bit m_disp   = 0;
    bit m_insuf  = 0;
    bit m_rej    = 0;
    int model_price [4] = '{3, 5, 7, 9};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = P_IDLE; m_credit = 0; m_sel = 0;
            m_disp = 0; m_insuf = 0; m_rej = 0;
        end else begin
            m_disp = 0; m_insuf = 0; m_rej = 0;
            if (m_phase == P_IDLE) begin
                if (bus.coin_valid) begin
                    m_credit = int'(bus.coin_val);
                    m_phase  = P_COLLECT;
                end
            end else if (m_phase == P_COLLECT) begin
                if (bus.coin_valid) begin
                    if (m_credit + int'(bus.coin_val) > 15) m_rej = 1;
                    else m_credit += int'(bus.coin_val);
                end
                if (bus.cancel) begin
                    m_phase = (m_credit > 0) ? P_CHANGE : P_IDLE;
                end else if (bus.item_valid) begin
                    m_sel   = int'(bus.item_sel);
                    m_phase = P_CHECK;
                end
            end else if (m_phase == P_CHECK) begin
                m_rej = bus.coin_valid;
                if (m_credit >= model_price[m_sel]) begin
                    m_credit -= model_price[m_sel];
                    m_disp  = 1;
                    m_phase = (m_credit > 0) ? P_CHANGE : P_IDLE;
                end else begin
                    m_insuf = 1;
                    m_phase = P_COLLECT;
                end
            end else begin
                m_rej = bus.coin_valid;
                if (bus.change_ack) begin
                    m_credit = 0;
                    m_phase  = P_IDLE;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("mux_sel",      int'(bus.mux_sel),      m_sel);
            chk("dispense",     int'(bus.dispense),     int'(m_disp));
            chk("insufficient", int'(bus.insufficient), int'(m_insuf));
            chk("coin_reject",  int'(bus.coin_reject),  int'(m_rej));
            chk("change_valid", int'(bus.change_valid), (m_phase == P_CHANGE) ? 1 : 0);
            chk("change_amt",   int'(bus.change_amt),   (m_phase == P_CHANGE) ? m_credit : 0);
            chk("credit",       int'(bus.credit),       m_credit);
            chk("busy",         int'(bus.busy),
                (m_phase == P_CHECK || m_phase == P_CHANGE) ? 1 : 0);
        end
    end

    // ---------------- stimulus ----------------
    // Drives one cycle of inputs from a negedge, returns at the next negedge.
    task automatic step(input bit cv, input int cval, input bit iv, input int isel,
                        input bit can, input bit ack);
        int cv4;
        int is2;
        cv4 = cval;
        is2 = isel;
        bus.coin_valid = cv;
        bus.coin_val   = cv4[3:0];
        bus.item_valid = iv;
        bus.item_sel   = is2[1:0];
        bus.cancel     = can;
        bus.change_ack = ack;
        @(negedge clk);
        bus.coin_valid = 1'b0;
        bus.coin_val   = 4'd0;
        bus.item_valid = 1'b0;
        bus.item_sel   = 2'd0;
        bus.cancel     = 1'b0;
        bus.change_ack = 1'b0;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bus.coin_valid = 1'b0;
        bus.coin_val   = 4'd0;
        bus.item_valid = 1'b0;
        bus.item_sel   = 2'd0;
        bus.cancel     = 1'b0;
        bus.change_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst credit",       int'(bus.credit),       0);
        chk("rst busy",         int'(bus.busy),         0);
        chk("rst change_valid", int'(bus.change_valid), 0);
        chk("rst mux_sel",      int'(bus.mux_sel),      0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // 5 + 5, item 1 (price 5) -> dispense, change 5.
        step(1, 5, 0, 0, 0, 0);
        step(1, 5, 0, 0, 0, 0);
        chk("s1 credit", int'(bus.credit), 10);
        step(0, 0, 1, 1, 0, 0);
        chk("s1 busy in check", int'(bus.busy), 1);
        idle();
        chk("s1 dispense",   int'(bus.dispense),     1);
        chk("s1 mux_sel",    int'(bus.mux_sel),      1);
        chk("s1 change_vld", int'(bus.change_valid), 1);
        chk("s1 change_amt", int'(bus.change_amt),   5);
        step(0, 0, 0, 0, 0, 1);
        chk("s1 credit after ack", int'(bus.credit),       0);
        chk("s1 idle after ack",   int'(bus.change_valid), 0);

        // 2, item 3 (price 9) -> insufficient; then +7 -> dispense, no change.
        step(1, 2, 0, 0, 0, 0);
        step(0, 0, 1, 3, 0, 0);
        idle();
        chk("s2 insufficient", int'(bus.insufficient), 1);
        chk("s2 credit",       int'(bus.credit),       2);
        chk("s2 busy",         int'(bus.busy),         0);
        step(1, 7, 0, 0, 0, 0);
        step(0, 0, 1, 3, 0, 0);
        idle();
        chk("s2 dispense",   int'(bus.dispense),     1);
        chk("s2 no change",  int'(bus.change_valid), 0);
        chk("s2 credit",     int'(bus.credit),       0);

        // 10 + 6 overflows -> reject; then +5 reaches the maximum.
        step(1, 10, 0, 0, 0, 0);
        step(1, 6, 0, 0, 0, 0);
        chk("s3 coin_reject", int'(bus.coin_reject), 1);
        chk("s3 credit held", int'(bus.credit),      10);
        step(1, 5, 0, 0, 0, 0);
        chk("s3 credit max",  int'(bus.credit),      15);
        chk("s3 no reject",   int'(bus.coin_reject), 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1);

        // 4, cancel -> change 4, no dispense.
        step(1, 4, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("s4 change_vld", int'(bus.change_valid), 1);
        chk("s4 change_amt", int'(bus.change_amt),   4);
        chk("s4 no dispense", int'(bus.dispense),    0);
        step(0, 0, 0, 0, 0, 1);

        // Credit 1, then coin 2 together with item 0 (price 3) -> exact dispense.
        step(1, 1, 0, 0, 0, 0);
        step(1, 2, 1, 0, 0, 0);
        chk("s5 credit 3", int'(bus.credit), 3);
        idle();
        chk("s5 dispense", int'(bus.dispense),     1);
        chk("s5 no change", int'(bus.change_valid), 0);
        chk("s5 credit 0", int'(bus.credit),       0);

        // Reset while holding change 6.
        step(1, 6, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("s6 change_amt", int'(bus.change_amt), 6);
        #2 rst = 1'b1;
        #1;
        chk("s6 rst change_vld", int'(bus.change_valid), 0);
        chk("s6 rst change_amt", int'(bus.change_amt),   0);
        chk("s6 rst credit",     int'(bus.credit),       0);
        chk("s6 rst busy",       int'(bus.busy),         0);
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 0, 0, 1);
        chk("s6 ack ignored vld",    int'(bus.change_valid), 0);
        chk("s6 ack ignored credit", int'(bus.credit),       0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 35, $urandom_range(0, 15),
                 $urandom_range(0, 99) < 20, $urandom_range(0, 3),
                 $urandom_range(0, 99) < 5,  $urandom_range(0, 99) < 35);
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
